mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single-port data RAM between two requesters: the instruction-fetch path and the load/store path (the ram_read_enable / ram_write_enable consumer).
Uses round-robin arbitration with a registered req/gnt handshake, then sequences one RAM access at a time.
Accounts for a configurable RAM read latency and returns read data with a one-cycle valid pulse.
Sits between the PC/fetch logic, the control-unit memory signals and the RAM instance.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 32, data width
RAM_LAT, 1, cycles from the RAM issue cycle to valid ram_rdata; legal range 1..4; 0 is illegal

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_gnt is seen
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle pulse; if_rdata holds the fetched word
if_rdata  out  DATA_W  last fetched word, held
d_req  in  1  load/store request; held high until d_gnt is seen
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  load/store address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle grant pulse to load/store
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  DATA_W  last loaded word, held; unchanged by stores
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_read_enable  out  1  RAM read strobe
ram_write_enable  out  1  RAM write strobe
ram_rdata  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE. All outputs clear to 0, including rdata registers, ram_addr and ram_wdata.
  - last_owner resets to FETCH, so the first contention goes to data.
  - Reset mid-transaction abandons the transaction; no rvalid is ever produced for it.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from the state and latched registers only; there is no combinational path from the req inputs to any output.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: grant that requester.
  - Both req high: grant the requester that is not last_owner.
  - On grant, latch owner, addr, we (fetch forces we=0) and wdata; update last_owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - The matching gnt pulses high for this cycle only.
  - ram_addr and ram_wdata come from the latches.
  - ram_read_enable = !we; ram_write_enable = we; both are 0 in every other state.
  - Read: go to WAIT with counter = RAM_LAT.
  - Write: go to RESP.
- WAIT (RAM_LAT cycles):
  - The counter decrements each cycle.
  - In the cycle where the counter reaches 1, capture ram_rdata into the owner's rdata register, then go to RESP.
- RESP (1 cycle): pulse the owner's rvalid, then go to IDLE. A new grant is possible in the following cycle.
- Timing: with a request seen in IDLE at cycle T:
  - gnt at T+1.
  - Read rvalid at T+2+RAM_LAT.
  - Write d_rvalid at T+2.
  - Back-to-back throughput is one access per RAM_LAT+3 cycles for reads and 3 cycles for writes.
- Requester protocol:
  - Requesters must drop req in the cycle after seeing gnt.
  - The arbiter ignores req outside IDLE, so there is no double grant.
  - A req dropped before gnt is treated as withdrawn.
- Ownership: rdata of the non-owner is never modified; at most one rvalid is high per cycle; at most one gnt is high per cycle.
- Address width: addresses pass through unmodified; there is no wrap or range check.

Test Plan:
- Reset: hold reset low 3 cycles with if_req=1 -> all outputs 0, busy 0, no gnt; release -> if_gnt at the 2nd edge after release.
- Single read, RAM_LAT=1: if_req, if_addr=8'h04 at T, RAM word 4 = 32'hDEADBEEF -> if_gnt@T+1, ram_read_enable@T+1 with ram_addr=4, if_rvalid@T+3 with if_rdata=32'hDEADBEEF.
- Store then load, RAM_LAT=3: d_we=1, d_addr=8'h10, d_wdata=32'h12345678 -> ram_write_enable one cycle, d_rvalid@T+2 with d_rdata unchanged; then load of 8'h10 -> d_rvalid 5 cycles after req with d_rdata=32'h12345678.
- Contention: if_req and d_req high continuously from reset -> grants alternate D, IF, D, IF; never two gnts in one cycle.
- Reset mid-WAIT (RAM_LAT=4): assert reset during WAIT -> no rvalid; after release a fresh if_req completes normally.
- RAM_LAT sweep 1..4: if_rvalid arrives exactly RAM_LAT+2 cycles after req; ram enables are never asserted outside ISSUE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between instruction fetch and load/store.
// One access is in flight at a time; read data returns with a one-cycle rvalid pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       owner_data;
  logic       last_data;
  logic       acc_we;
  logic [2:0] lat_cnt;
  logic       pick_data;

  // Data wins when it is the only requester, or on contention when fetch owned the last access.
  assign pick_data = d_req && (!if_req || !last_data);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      owner_data       <= 1'b0;
      last_data        <= 1'b0;
      acc_we           <= 1'b0;
      lat_cnt          <= '0;
      if_gnt           <= 1'b0;
      d_gnt            <= 1'b0;
      if_rvalid        <= 1'b0;
      d_rvalid         <= 1'b0;
      if_rdata         <= '0;
      d_rdata          <= '0;
      ram_addr         <= '0;
      ram_wdata        <= '0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
    end else begin
      if_gnt           <= 1'b0;
      d_gnt            <= 1'b0;
      if_rvalid        <= 1'b0;
      d_rvalid         <= 1'b0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_data       <= pick_data;
            last_data        <= pick_data;
            acc_we           <= pick_data && d_we;
            ram_addr         <= pick_data ? d_addr : if_addr;
            if (pick_data) ram_wdata <= d_wdata;
            if_gnt           <= !pick_data;
            d_gnt            <= pick_data;
            ram_read_enable  <= !(pick_data && d_we);
            ram_write_enable <= pick_data && d_we;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (acc_we) begin
            d_rvalid <= 1'b1;
            state    <= RESP;
          end else begin
            lat_cnt <= 3'(RAM_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          // The RAM output is valid during the last wait cycle, so capture it on that edge.
          if (lat_cnt == 3'd1) begin
            if (owner_data) begin
              d_rdata  <= ram_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= ram_rdata;
              if_rvalid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
